// File: rtl/bcd_seq_converter_ctrl_if.sv
// Handshake bundle for the sequential binary-to-BCD controller.
// Signals:
//   in_valid/in_ready/in_bin          operand channel (producer -> controller)
//   out_valid/out_ready/out_bcd       result channel (controller -> consumer)
//   overflow                          result saturated, qualified by out_valid
//   busy                              conversion in progress
//   out_blank                         leading-zero blank mask (BCD_BLANK_LZ_EN only)
// Modports: master = producer/consumer side, slave = controller side.
// Optional feature macro: BCD_BLANK_LZ_EN.
interface bcd_seq_converter_ctrl_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  overflow;
  logic                  busy;
`ifdef BCD_BLANK_LZ_EN
  logic [DIGITS-1:0]     out_blank;

  modport master (
    output in_valid, in_bin, out_ready,
    input  in_ready, out_valid, out_bcd, overflow, busy, out_blank
  );
  modport slave (
    input  in_valid, in_bin, out_ready,
    output in_ready, out_valid, out_bcd, overflow, busy, out_blank
  );
`else
  modport master (
    output in_valid, in_bin, out_ready,
    input  in_ready, out_valid, out_bcd, overflow, busy
  );
  modport slave (
    input  in_valid, in_bin, out_ready,
    output in_ready, out_valid, out_bcd, overflow, busy
  );
`endif
endinterface

// File: rtl/bcd_seq_converter_ctrl.sv
// Sequential binary-to-BCD converter (double-dabble, one operand bit per clock).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bcd_seq_converter_ctrl_if.slave: operand handshake in, BCD result
//          handshake out, overflow, busy (and out_blank with BCD_BLANK_LZ_EN)
// Optional feature macro: BCD_BLANK_LZ_EN adds a registered leading-zero
// blank mask next to out_bcd.
module bcd_seq_converter_ctrl #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_seq_converter_ctrl_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [BCD_W-1:0] SAT = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d, bin_sh;
  logic [BCD_W-1:0]   acc_q, acc_d, adj, acc_sh;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d, ovf_all;
  logic               overflow_q, overflow_d;
  logic               valid_q, busy_q;
  logic               carry, in_ready_c, accept_c, last_c;
`ifdef BCD_BLANK_LZ_EN
  logic [DIGITS-1:0]  blank_q, blank_d;

  // Bit i set when digit i and every higher digit are zero; digit 0 is always shown.
  function automatic logic [DIGITS-1:0] lz_blank(input logic [BCD_W-1:0] v);
    logic zero_run;
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run    = zero_run && (v[4*i +: 4] == 4'd0);
      lz_blank[i] = zero_run;
    end
  endfunction
`endif

  // A new result may be taken over the cycle the old one is consumed.
  assign in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;
  assign last_c     = (cnt_q == CNT_W'(BIN_W - 1));

  // Add-3 correction on every accumulator digit >= 5.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Shift {acc, bin} left by one; the bit leaving the top digit means overflow.
  assign carry   = adj[BCD_W-1];
  assign acc_sh  = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign bin_sh  = {bin_q[BIN_W-2:0], 1'b0};
  assign ovf_all = ovf_q | carry;

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
`ifdef BCD_BLANK_LZ_EN
    blank_d    = blank_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          bin_d   = bus.in_bin;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = SHIFT;
        end else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = acc_sh;
        bin_d = bin_sh;
        cnt_d = cnt_q + 1'b1;
        ovf_d = ovf_all;
        if (last_c) begin
          state_d    = DONE;
          overflow_d = ovf_all;
          bcd_d      = ovf_all ? SAT : acc_sh;
`ifdef BCD_BLANK_LZ_EN
          blank_d    = ovf_all ? '0 : lz_blank(acc_sh);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef BCD_BLANK_LZ_EN
      blank_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      valid_q    <= (state_d == DONE);
      busy_q     <= (state_d == SHIFT);
`ifdef BCD_BLANK_LZ_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_bcd   = bcd_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = busy_q;
`ifdef BCD_BLANK_LZ_EN
  assign bus.out_blank = blank_q;
`endif

endmodule
